// File: rtl/lcd_pkg.sv
// Shared types, constants and elaboration-time helpers for the LCD sequencer.
// Optional build macro: LCD_INIT_SEQ_EN adds the power-up initialisation states.
package lcd_pkg;

  // FSM state encoding
  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    NEXT
`ifdef LCD_INIT_SEQ_EN
    ,
    INIT_POWER,
    INIT_LOAD
`endif
  } lcd_state_e;

  // Memory word layout as presented on i_data
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] db;
  } lcd_word_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] INIT_DB_8BIT = 8'h30;
  localparam logic [7:0] INIT_DB_4BIT = 8'h20;

  localparam longint unsigned NS_PER_S = 64'd1_000_000_000;

  // Clock cycles covering t_ns at clock_hz, rounded up, never less than one
  function automatic int unsigned cycles(input longint unsigned clock_hz,
                                         input longint unsigned t_ns);
    longint unsigned c;
    c = (clock_hz * t_ns + NS_PER_S - 64'd1) / NS_PER_S;
    if (c == 64'd0) c = 64'd1;
    return 32'(c);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear display and return home (0x02/0x03) need the long execution wait
  function automatic logic is_long(input lcd_word_t w);
    return !w.rs && ((w.db == CMD_CLEAR) || (w.db[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used for every timed phase of the sequencer.
// Ports: i_clk, i_rst_n, load (strobe), load_val (value to load), zero_c (count is zero).
// A phase lasting N cycles is obtained by loading N-1 on entry and leaving on zero_c.
module lcd_delay_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero_c
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; otherwise count down and stick at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780-class character LCD sequencer: walks a memory address range, fetches
// one {RS,RW,DB} word per address and strobes it onto the LCD bus (8- or 4-bit),
// then waits out the controller execution time.
// Ports: i_clk, i_rst_n (async, active-low), i_start, i_addr_begin/i_addr_end
// (inclusive range, wraps modulo 2^WIDTH_MEM), i_data (sync-read memory word),
// o_addr, o_busy, o_done/o_overflow (one-cycle pulses at sequence end),
// o_rs, o_rw, o_db, o_E (all registered LCD pins).
// Optional build macro: LCD_INIT_SEQ_EN runs the HD44780 power-up sequence after reset.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned CLOCK      = 50_000_000,
  parameter int unsigned WIDTH_MEM  = 4,
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned T_SETUP_NS = 60,
  parameter int unsigned T_PW_NS    = 450,
  parameter int unsigned T_HOLD_NS  = 20,
  parameter int unsigned T_SHORT_US = 37,
  parameter int unsigned T_LONG_US  = 1530
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WIDTH_MEM-1:0] i_addr_begin,
  input  logic [WIDTH_MEM-1:0] i_addr_end,
  input  logic [9:0]           i_data,
  output logic [WIDTH_MEM-1:0] o_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic                 o_rs,
  output logic                 o_rw,
  output logic [BUS_WIDTH-1:0] o_db,
  output logic                 o_E
);

  localparam int unsigned SETUP_CYC = cycles(64'(CLOCK), 64'(T_SETUP_NS));
  localparam int unsigned PW_CYC    = cycles(64'(CLOCK), 64'(T_PW_NS));
  localparam int unsigned HOLD_CYC  = cycles(64'(CLOCK), 64'(T_HOLD_NS));
  localparam int unsigned SHORT_CYC = cycles(64'(CLOCK), 64'(T_SHORT_US) * 64'd1000);
  localparam int unsigned LONG_CYC  = cycles(64'(CLOCK), 64'(T_LONG_US) * 64'd1000);
  localparam int unsigned BASE_MAX  = max2(max2(SETUP_CYC, PW_CYC),
                                           max2(HOLD_CYC, max2(SHORT_CYC, LONG_CYC)));
`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned PWR_CYC   = cycles(64'(CLOCK), 64'd15_000_000);
  localparam int unsigned INIT1_CYC = cycles(64'(CLOCK), 64'd4_100_000);
  localparam int unsigned INIT2_CYC = cycles(64'(CLOCK), 64'd100_000);
  localparam int unsigned MAX_CYC   = max2(BASE_MAX, max2(PWR_CYC, max2(INIT1_CYC, INIT2_CYC)));
  // 4-bit mode appends the 0x2 interface-switch strobe as a fourth step
  localparam logic [1:0]  LAST_STEP = (BUS_WIDTH == 4) ? 2'd3 : 2'd2;
`else
  localparam int unsigned MAX_CYC   = BASE_MAX;
`endif
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  lcd_state_e           state_q, state_d;
  logic [WIDTH_MEM-1:0] addr_d;
  logic [WIDTH_MEM-1:0] end_q, end_d;
  logic [3:0]           lo_nib_q, lo_nib_d;
  logic                 nib_q, nib_d;
  logic [CW-1:0]        wait_q, wait_d;
  logic                 busy_d, done_d, ovf_d, rs_d, rw_d, e_d;
  logic [BUS_WIDTH-1:0] db_d;
  logic                 cnt_load;
  logic [CW-1:0]        cnt_val;
  logic                 cnt_zero_c;
  logic                 init_run_c;
  lcd_word_t            word_in;

`ifdef LCD_INIT_SEQ_EN
  logic                 init_done_q, init_done_d;
  logic [1:0]           step_q, step_d;
  assign init_run_c = !init_done_q;
`else
  assign init_run_c = 1'b0;
`endif

  assign word_in = lcd_word_t'(i_data);

  // Bus value for a byte: full byte in 8-bit mode, selected nibble in 4-bit mode
  function automatic logic [BUS_WIDTH-1:0] bus_val(input logic [7:0] b, input logic hi);
    logic [7:0] s;
    s = (BUS_WIDTH == 4 && hi) ? (b >> 4) : b;
    return BUS_WIDTH'(s);
  endfunction

  lcd_delay_counter #(
    .WIDTH (CW)
  ) u_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero_c   (cnt_zero_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = o_addr;
    end_d    = end_q;
    lo_nib_d = lo_nib_q;
    nib_d    = nib_q;
    wait_d   = wait_q;
    rs_d     = o_rs;
    rw_d     = o_rw;
    db_d     = o_db;
    done_d   = 1'b0;
    ovf_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
`ifdef LCD_INIT_SEQ_EN
    init_done_d = init_done_q;
    step_d      = step_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef LCD_INIT_SEQ_EN
        if (!init_done_q) begin
          state_d  = INIT_POWER;
          cnt_load = 1'b1;
          cnt_val  = CW'(PWR_CYC - 1);
        end else
`endif
        if (i_start) begin
          addr_d   = i_addr_begin;
          end_d    = i_addr_end;
          state_d  = FETCH;
          cnt_load = 1'b1;
          cnt_val  = CW'(1);
        end
      end

      // Two cycles: the synchronous memory returns data one cycle after o_addr moves
      FETCH: begin
        if (cnt_zero_c) begin
          lo_nib_d = word_in.db[3:0];
          nib_d    = 1'b0;
          wait_d   = is_long(word_in) ? CW'(LONG_CYC - 1) : CW'(SHORT_CYC - 1);
          rs_d     = word_in.rs;
          rw_d     = word_in.rw;
          db_d     = bus_val(word_in.db, 1'b1);
          state_d  = SETUP;
          cnt_load = 1'b1;
          cnt_val  = CW'(SETUP_CYC - 1);
        end
      end

      SETUP: begin
        if (cnt_zero_c) begin
          state_d  = PULSE;
          cnt_load = 1'b1;
          cnt_val  = CW'(PW_CYC - 1);
        end
      end

      PULSE: begin
        if (cnt_zero_c) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = CW'(HOLD_CYC - 1);
        end
      end

      // In 4-bit mode the low nibble follows the high one; init writes are single strobes
      HOLD: begin
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          if (BUS_WIDTH == 4 && !nib_q && !init_run_c) begin
            nib_d   = 1'b1;
            db_d    = bus_val({4'h0, lo_nib_q}, 1'b0);
            state_d = SETUP;
            cnt_val = CW'(SETUP_CYC - 1);
          end else begin
            state_d = WAIT;
            cnt_val = wait_q;
          end
        end
      end

      WAIT: begin
        if (cnt_zero_c) begin
`ifdef LCD_INIT_SEQ_EN
          if (!init_done_q) begin
            if (step_q == LAST_STEP) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              step_d  = step_q + 2'd1;
              state_d = INIT_LOAD;
            end
          end else
`endif
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (o_addr == end_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          addr_d   = o_addr + WIDTH_MEM'(1);
          state_d  = FETCH;
          cnt_load = 1'b1;
          cnt_val  = CW'(1);
        end
      end

`ifdef LCD_INIT_SEQ_EN
      INIT_POWER: begin
        if (cnt_zero_c) state_d = INIT_LOAD;
      end

      // Steps 0..2 send 0x3 (function set, 8-bit), step 3 sends 0x2 (switch to 4-bit)
      INIT_LOAD: begin
        rs_d     = 1'b0;
        rw_d     = 1'b0;
        nib_d    = 1'b0;
        db_d     = bus_val((step_q == 2'd3) ? INIT_DB_4BIT : INIT_DB_8BIT, 1'b1);
        wait_d   = (step_q == 2'd0) ? CW'(INIT1_CYC - 1) :
                   (step_q == 2'd3) ? CW'(SHORT_CYC - 1) : CW'(INIT2_CYC - 1);
        state_d  = SETUP;
        cnt_load = 1'b1;
        cnt_val  = CW'(SETUP_CYC - 1);
      end
`endif

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    e_d    = (state_d == PULSE);
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      o_addr     <= '0;
      end_q      <= '0;
      lo_nib_q   <= '0;
      nib_q      <= 1'b0;
      wait_q     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      o_rs       <= 1'b0;
      o_rw       <= 1'b0;
      o_db       <= '0;
      o_E        <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_addr     <= addr_d;
      end_q      <= end_d;
      lo_nib_q   <= lo_nib_d;
      nib_q      <= nib_d;
      wait_q     <= wait_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_overflow <= ovf_d;
      o_rs       <= rs_d;
      o_rw       <= rw_d;
      o_db       <= db_d;
      o_E        <= e_d;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  // Power-up sequence progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_done_q <= 1'b0;
      step_q      <= 2'd0;
    end else begin
      init_done_q <= init_done_d;
      step_q      <= step_d;
    end
  end
`endif

endmodule
